// File: rtl/delay_sum_beamformer_pkg.sv
// Shared parameters, types and helpers for the 4x4 delay-and-sum beamformer.
// Optional feature macro: DELAY_SUM_NORM_EN (output is the rounded mean instead of the raw sum).
package beamform_pkg;

  localparam int N_CH       = 16;
  localparam int SAMPLE_W   = 16;
  localparam int DELTA_W    = 8;
  localparam int DEPTH_LOG2 = 8;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int ACC_W      = SAMPLE_W + 4;
  localparam int FILL_W     = DEPTH_LOG2 + 1;
  localparam int CH_W       = $clog2(N_CH);

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic        [DELTA_W-1:0]  delta_t;
  typedef logic signed [ACC_W-1:0]    acc_t;
  typedef logic        [DEPTH_LOG2-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Widen one channel sample to accumulator width, keeping its sign.
  function automatic acc_t sign_extend(input sample_t s);
    return acc_t'(s);
  endfunction

endpackage

// File: rtl/delay_sum_beamformer_if.sv
// Frame input / beamformed output bundle of the delay-and-sum beamformer.
// master = frame source side, slave = beamformer side.
interface delay_sum_beamformer_if;
  import beamform_pkg::*;

  logic                  i_valid;
  sample_t [N_CH-1:0]    i_sample;
  delta_t  [N_CH-1:0]    i_delta;
  logic                  o_ready;
  logic                  o_valid;
  acc_t                  o_sample;
  logic                  o_overrun;

  modport master (
    output i_valid, i_sample, i_delta,
    input  o_ready, o_valid, o_sample, o_overrun
  );

  modport slave (
    input  i_valid, i_sample, i_delta,
    output o_ready, o_valid, o_sample, o_overrun
  );

endinterface

// File: rtl/delay_sum_beamformer_channel_ring_buffer.sv
// Per-channel sample history: 256-entry ring, synchronous write,
// asynchronous read so the accumulator sees the addressed sample in the same cycle.
module channel_ring_buffer
  import beamform_pkg::*;
(
  input  logic    i_clk,
  input  logic    i_we,
  input  addr_t   i_waddr,
  input  sample_t i_wdata,
  input  addr_t   i_raddr,
  output sample_t o_rdata
);

  sample_t r_mem [DEPTH];

  // Store the accepted frame's sample at the current write pointer.
  // NOTE: the memory has no reset; stale contents are masked by the fill count in the top.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/delay_sum_beamformer.sv
// Delay-and-sum beamformer: buffers 16 mic channels, then sums each channel's
// sample delayed by its own delta, one channel per cycle, one output per frame.
// Optional feature macro: DELAY_SUM_NORM_EN -> output is (sum + 8) >>> 4 instead of raw sum.
module delay_sum_beamformer
  import beamform_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  delay_sum_beamformer_if.slave  bus
);

  state_t               r_state;
  state_t               w_next_state;
  addr_t                r_wr_ptr;
  logic [FILL_W-1:0]    r_fill;
  delta_t [N_CH-1:0]    r_delta_q;
  logic [CH_W-1:0]      r_ch_cnt;
  acc_t                 r_acc;
  acc_t                 r_sample;
  logic                 r_valid;
  logic                 r_overrun;

  logic                 w_ready;
  logic                 w_accept;
  logic                 w_last_ch;
  delta_t               w_cur_delta;
  addr_t                w_rd_addr;
  sample_t              w_rd_data [N_CH];
  acc_t                 w_term;
  acc_t                 w_acc_next;
  acc_t                 w_result;

  assign w_ready     = (r_state == IDLE);
  assign w_accept    = bus.i_valid && w_ready;
  assign w_last_ch   = (r_ch_cnt == CH_W'(N_CH - 1));
  assign w_cur_delta = r_delta_q[r_ch_cnt];

  // Read address wraps naturally in 8 bits; delta 0 hits the sample written this frame.
  assign w_rd_addr   = r_wr_ptr - w_cur_delta;

  genvar g;
  generate
    for (g = 0; g < N_CH; g++) begin : g_ch
      channel_ring_buffer u_ring (
        .i_clk   (i_clk),
        .i_we    (w_accept),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.i_sample[g]),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data[g])
      );
    end
  endgenerate

  // A delayed tap counts only if that many frames have been written since reset.
  assign w_term     = ({1'b0, w_cur_delta} < r_fill) ? sign_extend(w_rd_data[r_ch_cnt]) : '0;
  assign w_acc_next = r_acc + w_term;

`ifdef DELAY_SUM_NORM_EN
  // Round-half-up mean of 16 channels; one guard bit keeps +8 from overflowing.
  assign w_result = acc_t'(($signed({w_acc_next[ACC_W-1], w_acc_next}) + 21'sd8) >>> 4);
`else
  assign w_result = w_acc_next;
`endif

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: IDLE -> ACC on accept, ACC for 16 channels, OUT for one cycle.
  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept)  w_next_state = ACC;
      ACC:     if (w_last_ch) w_next_state = OUT;
      OUT:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: frame capture, accumulation, output register, pointers and overrun flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr  <= '0;
      r_fill    <= '0;
      r_delta_q <= '0;
      r_ch_cnt  <= '0;
      r_acc     <= '0;
      r_sample  <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (bus.i_valid && !w_ready) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_delta_q <= bus.i_delta;
            if (r_fill != FILL_W'(DEPTH)) begin
              r_fill <= r_fill + FILL_W'(1);
            end
            r_ch_cnt <= '0;
            r_acc    <= '0;
          end
        end
        ACC: begin
          r_acc    <= w_acc_next;
          r_ch_cnt <= r_ch_cnt + CH_W'(1);
          // Result is registered on the last channel so it is valid throughout OUT.
          if (w_last_ch) begin
            r_sample <= w_result;
            r_valid  <= 1'b1;
          end
        end
        OUT: begin
          r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.o_ready   = w_ready;
  assign bus.o_valid   = r_valid;
  assign bus.o_sample  = r_sample;
  assign bus.o_overrun = r_overrun;

endmodule

// File: tb/tb_delay_sum_beamformer.sv
// Self-checking bench for delay_sum_beamformer: directed scenarios plus random
// frames, compared against a frame-history reference model.
module tb_delay_sum_beamformer;
  import beamform_pkg::*;

  typedef int frame_t [N_CH];

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  delay_sum_beamformer_if bif ();

  delay_sum_beamformer dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: full per-channel history indexed by frame number since reset.
  int hist [N_CH][$];
  int n_frames;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int c = 0; c < N_CH; c++) hist[c].delete();
    n_frames = 0;
  endfunction

  function automatic int model_frame(input frame_t s, input frame_t d);
    int n;
    int avail;
    int sum;
    n = n_frames;
    for (int c = 0; c < N_CH; c++) hist[c].push_back(s[c]);
    n_frames++;
    avail = (n_frames > DEPTH) ? DEPTH : n_frames;
    sum = 0;
    for (int c = 0; c < N_CH; c++) begin
      if (d[c] < avail) sum += hist[c][n - d[c]];
    end
`ifdef DELAY_SUM_NORM_EN
    sum = (sum + 8) >>> 4;
`endif
    return sum;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #12;
    check("rst_valid",   bif.o_valid,   0);
    check("rst_sample",  bif.o_sample,  0);
    check("rst_overrun", bif.o_overrun, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    #1;
    check("rst_ready", bif.o_ready, 1);
  endtask

  // Send one frame, optionally poking i_valid mid-accumulation, and check the result.
  task automatic run_frame(input frame_t s, input frame_t d, input bit poke, input string tag);
    int  exp;
    int  lat;
    bit  seen;
    logic signed [SAMPLE_W-1:0] junk;
    @(negedge clk);
    check({tag, "_ready"}, bif.o_ready, 1);
    bif.i_valid = 1'b1;
    for (int c = 0; c < N_CH; c++) begin
      bif.i_sample[c] = sample_t'(s[c]);
      bif.i_delta[c]  = delta_t'(d[c]);
    end
    @(posedge clk);
    #1;
    bif.i_valid = 1'b0;
    // Scramble inputs after accept: the frame in flight must not see them.
    for (int c = 0; c < N_CH; c++) begin
      junk = $urandom;
      bif.i_sample[c] = junk;
      bif.i_delta[c]  = delta_t'($urandom);
    end
    exp  = model_frame(s, d);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      if (poke && lat == 3) bif.i_valid = 1'b1;
      if (poke && lat == 5) bif.i_valid = 1'b0;
      @(posedge clk);
      lat++;
      #1;
      seen = bif.o_valid;
    end
    bif.i_valid = 1'b0;
    check({tag, "_latency"}, lat, 16);
    check({tag, "_sample"}, bif.o_sample, exp);
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, bif.o_valid, 0);
    check({tag, "_hold"}, bif.o_sample, exp);
  endtask

  initial begin
    frame_t s;
    frame_t d;
    logic signed [SAMPLE_W-1:0] rs;
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b1;
    bif.i_valid = 1'b0;
    bif.i_sample = '0;
    bif.i_delta  = '0;
    model_clear();

    // Basic: all samples 100, zero delay.
    do_reset();
    for (int c = 0; c < N_CH; c++) begin s[c] = 100; d[c] = 0; end
    run_frame(s, d, 1'b0, "basic");
`ifdef DELAY_SUM_NORM_EN
    check("basic_const", bif.o_sample, 100);
`else
    check("basic_const", bif.o_sample, 1600);
`endif

    // Focal (0,0): corners 150, edges 149, inner 147; impulse at frame 0.
    do_reset();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if ((r == 0 || r == 3) && (c == 0 || c == 3)) d[r*4+c] = 150;
        else if (r >= 1 && r <= 2 && c >= 1 && c <= 2) d[r*4+c] = 147;
        else d[r*4+c] = 149;
      end
    end
    for (int f = 0; f < 152; f++) begin
      for (int c = 0; c < N_CH; c++) s[c] = (f == 0) ? 1000 : 0;
      run_frame(s, d, 1'b0, "focal");
`ifndef DELAY_SUM_NORM_EN
      if (f == 149) check("focal_edges", bif.o_sample, 8000);
`endif
    end

    // Warm-up: delta 5 must read zero until 5 frames of history exist.
    do_reset();
    for (int f = 0; f < 8; f++) begin
      for (int c = 0; c < N_CH; c++) begin s[c] = 10; d[c] = 5; end
      run_frame(s, d, 1'b0, "warmup");
    end

    // Wrap: ramp on ch0 with delta 3 across the write-pointer wrap.
    do_reset();
    for (int f = 0; f < 300; f++) begin
      for (int c = 0; c < N_CH; c++) begin s[c] = 0; d[c] = $urandom_range(0, 255); end
      s[0] = f % 256;
      d[0] = 3;
      run_frame(s, d, 1'b0, "wrap");
    end

    // Random frames with full history, any delta; poke i_valid during ACC.
    for (int f = 0; f < 40; f++) begin
      for (int c = 0; c < N_CH; c++) begin
        rs = $urandom;
        s[c] = rs;
        d[c] = $urandom_range(0, 255);
      end
      run_frame(s, d, (f % 7 == 3), "rand_full");
    end
    check("overrun_set", bif.o_overrun, 1);

    // Random frames right after reset exercise the fill boundary.
    do_reset();
    for (int f = 0; f < 30; f++) begin
      for (int c = 0; c < N_CH; c++) begin
        rs = $urandom;
        s[c] = rs;
        d[c] = $urandom_range(0, 40);
      end
      run_frame(s, d, 1'b0, "rand_fill");
    end
    check("overrun_clear", bif.o_overrun, 0);
    check("hold_nonzero", (bif.o_sample != 0) || (n_frames == 0), 1);

    // Reset mid-accumulation.
    @(negedge clk);
    bif.i_valid = 1'b1;
    for (int c = 0; c < N_CH; c++) begin bif.i_sample[c] = 16'sd500; bif.i_delta[c] = '0; end
    @(posedge clk);
    #1;
    bif.i_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid",  bif.o_valid,  0);
    check("midrst_sample", bif.o_sample, 0);
    check("midrst_ready",  bif.o_ready,  1);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    #1;
    check("midrst_ready_rel", bif.o_ready, 1);
    for (int c = 0; c < N_CH; c++) begin
      rs = $urandom;
      s[c] = rs;
      d[c] = (c % 3 == 0) ? 0 : $urandom_range(1, 255);
    end
    run_frame(s, d, 1'b0, "midrst_next");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
